// File: rtl/clock_phase_gen.sv
// Bus timing enables derived from CLK: CPU tick, colour clock, E clock and a
// reset stretched by a number of CPU ticks. Everything is a CLK enable/level.
module clock_phase_gen #(
  parameter int DIV_C7     = 4,
  parameter int E_LOW      = 6,
  parameter int E_HIGH     = 4,
  parameter int RESET_HOLD = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic HALT,
  output logic C7_EN,
  output logic CCK,
  output logic CCK_RISE,
  output logic CCK_FALL,
  output logic E,
  output logic E_RISE,
  output logic E_FALL,
  output logic RESET_OUT
);

  localparam int E_PER = E_LOW + E_HIGH;
  localparam int DW    = $clog2(DIV_C7);
  localparam int EW    = $clog2(E_PER);
  localparam int RW    = (RESET_HOLD < 1) ? 1 : $clog2(RESET_HOLD + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_C7 - 1);
  localparam logic [EW-1:0] E_RISE_AT = EW'(E_LOW - 1);
  localparam logic [EW-1:0] E_LAST    = EW'(E_PER - 1);

  logic [DW-1:0] div_cnt;
  logic [EW-1:0] e_cnt;
  logic [RW-1:0] rst_cnt;
  logic          stretch;

  // Pulses decode registered counters only; RESET never reaches them directly.
  assign C7_EN    = (div_cnt == DIV_LAST) && !HALT;
  assign CCK_RISE = C7_EN && !CCK;
  assign CCK_FALL = C7_EN && CCK;
  assign E_RISE   = C7_EN && (e_cnt == E_RISE_AT);
  assign E_FALL   = C7_EN && (e_cnt == E_LAST);

  generate
    if (RESET_HOLD == 0) begin : g_no_hold
      assign stretch = 1'b0;
    end else begin : g_hold
      assign stretch = (rst_cnt < RW'(RESET_HOLD));
    end
  endgenerate

  // RESET_OUT reasserts combinationally in the same cycle RESET rises.
  assign RESET_OUT = RESET || stretch;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt <= '0;
      e_cnt   <= '0;
      rst_cnt <= '0;
      CCK     <= 1'b0;
      E       <= 1'b0;
    end else if (!HALT) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (C7_EN) begin
        CCK   <= ~CCK;
        e_cnt <= (e_cnt == E_LAST) ? '0 : e_cnt + 1'b1;
        if (E_RISE)
          E <= 1'b1;
        else if (E_FALL)
          E <= 1'b0;
        // Saturating: stops at RESET_HOLD so the stretch ends for good.
        if (stretch)
          rst_cnt <= rst_cnt + 1'b1;
      end
    end
  end

endmodule
